// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals around mem_arbiter.
// The slave modport is the arbiter; the master modport is the core plus memory side.
interface mem_arbiter_if;
  logic        IReq;
  logic [31:0] IAdr;
  logic [31:0] IRData;
  logic        IValid;
  logic        DReq;
  logic        DWrite;
  logic [31:0] DAdr;
  logic [31:0] DWData;
  logic [3:0]  DByteEn;
  logic [31:0] DRData;
  logic        DValid;
  logic        Err;
  logic        MemReq;
  logic        MemWrite;
  logic [31:0] MemAdr;
  logic [31:0] MemWData;
  logic [3:0]  MemByteEn;
  logic        MemAck;
  logic [31:0] MemRData;
  logic        Busy;

  modport slave (
    input  IReq, IAdr, DReq, DWrite, DAdr, DWData, DByteEn, MemAck, MemRData,
    output IRData, IValid, DRData, DValid, Err,
           MemReq, MemWrite, MemAdr, MemWData, MemByteEn, Busy
  );

  modport master (
    output IReq, IAdr, DReq, DWrite, DAdr, DWData, DByteEn, MemAck, MemRData,
    input  IRData, IValid, DRData, DValid, Err,
           MemReq, MemWrite, MemAdr, MemWData, MemByteEn, Busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Data side wins by default; a streak limit stops fetch starvation and a watchdog ends hung accesses.
module mem_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 255
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int SW   = $clog2(MAX_DSTREAK + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_DSTREAK);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   streak;
  logic [WD_W-1:0] wd;
  logic            grant_i, grant_d, ack, tmo;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == STREAK_MAX) ? v : v + SW'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    ack       = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.DReq && (!bus.IReq || (streak < STREAK_MAX))) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (bus.IReq) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        // An acknowledge arriving on the last watchdog cycle still counts as success
        if (bus.MemAck) begin
          ack       = 1'b1;
          state_nxt = RESP;
        end else if (wd == WD_LAST) begin
          tmo       = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.Busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak <= '0;
      wd     <= '0;
    end else begin
      if (grant_d)      streak <= bus.IReq ? sat_inc(streak) : '0;
      else if (grant_i) streak <= '0;

      if (ack || tmo)                          wd <= '0;
      else if (state == BUSY_I || state == BUSY_D) wd <= wd + WD_W'(1);
    end
  end

  // Memory-port registers: loaded on the grant edge and frozen until completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.MemReq    <= 1'b0;
      bus.MemWrite  <= 1'b0;
      bus.MemAdr    <= '0;
      bus.MemWData  <= '0;
      bus.MemByteEn <= '0;
    end else if (grant_d) begin
      bus.MemReq    <= 1'b1;
      bus.MemWrite  <= bus.DWrite;
      bus.MemAdr    <= bus.DAdr;
      bus.MemWData  <= bus.DWData;
      bus.MemByteEn <= bus.DByteEn;
    end else if (grant_i) begin
      bus.MemReq    <= 1'b1;
      bus.MemWrite  <= 1'b0;
      bus.MemAdr    <= bus.IAdr;
      bus.MemWData  <= '0;
      bus.MemByteEn <= 4'b1111;
    end else if (ack || tmo) begin
      bus.MemReq    <= 1'b0;
    end
  end

  // Response registers: valid/err pulse for one cycle, read data held until the next completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.IValid <= 1'b0;
      bus.DValid <= 1'b0;
      bus.Err    <= 1'b0;
      bus.IRData <= '0;
      bus.DRData <= '0;
    end else begin
      bus.IValid <= 1'b0;
      bus.DValid <= 1'b0;
      bus.Err    <= 1'b0;
      if (ack || tmo) begin
        bus.Err <= tmo;
        if (state == BUSY_I) begin
          bus.IValid <= 1'b1;
          bus.IRData <= tmo ? '0 : bus.MemRData;
        end else begin
          bus.DValid <= 1'b1;
          bus.DRData <= (tmo || bus.MemWrite) ? '0 : bus.MemRData;
        end
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified memory port between instruction fetch (I side) and load/store (D side) of the RV32 core.
- Registers the winning request onto the memory port and waits for the memory acknowledge. It then returns the data to the requester as a one-cycle valid pulse.
- Data side has priority, bounded by a starvation limit for fetch. A watchdog terminates hung transactions with an error.
- Sits between the core's fetch/LSU interfaces and the memory/bus model.

Parameters:
- MAX_DSTREAK, 4: consecutive D grants allowed while IReq is pending before I is forced to win.
- TIMEOUT, 255: cycles to wait for MemAck before aborting with error. Minimum 1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- IReq  input  1  fetch request, held until IValid.
- IAdr  input  32  fetch address, stable while IReq is high.
- IRData  output  32  fetched word, valid with IValid.
- IValid  output  1  one-cycle completion pulse for fetch.
- DReq  input  1  data request, held until DValid.
- DWrite  input  1  1 = store, 0 = load.
- DAdr  input  32  data address.
- DWData  input  32  store data.
- DByteEn  input  4  byte enables.
- DRData  output  32  load data, valid with DValid.
- DValid  output  1  one-cycle completion pulse for data.
- Err  output  1  high with I/DValid when the transaction timed out.
- MemReq  output  1  memory request.
- MemWrite  output  1  memory write.
- MemAdr  output  32  memory address.
- MemWData  output  32  memory write data.
- MemByteEn  output  4  memory byte enables (4'b1111 for fetch).
- MemAck  input  1  memory completion, sampled only while MemReq is high.
- MemRData  input  32  memory read data, valid with MemAck.
- Busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous): state IDLE, streak counter 0, watchdog 0. All outputs 0. An in-flight transaction is dropped with no valid pulse; requesters must reissue.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE grant rules:
  - DReq high and (IReq low or streak < MAX_DSTREAK) -> BUSY_D.
  - Otherwise IReq high -> BUSY_I.
  - Otherwise stay in IDLE.
- On entering BUSY_x, the Mem* outputs are loaded from the winner's inputs in the same edge, so MemReq rises one cycle after the request is sampled.
- Fetch drives MemWrite=0, MemByteEn=4'b1111, MemWData=0.
- Streak counter:
  - Increments on a D grant while IReq is high, saturating at MAX_DSTREAK.
  - Clears on any I grant.
  - Clears on a D grant while IReq is low.
- BUSY_x:
  - MemReq and Mem* are held constant.
  - Watchdog increments each cycle.
  - MemAck high -> capture MemRData (write: capture 0) into the x RData register, Err=0, go to RESP.
  - Watchdog reaching TIMEOUT without MemAck -> RData=0, Err=1, go to RESP.
  - MemAck in the same cycle the timeout is reached: MemAck wins, Err=0.
- Entering RESP: MemReq drops to 0 and the watchdog clears.
- RESP: xValid=1 for exactly this cycle, Err as captured, then IDLE.
  - The requester's Req in this cycle is ignored.
  - A requester may keep Req high to issue its next transaction; that request is evaluated in the following IDLE cycle.
- Minimum transaction time: request sampled at cycle n, MemAck at n+1, xValid at n+2, next MemReq at n+4.
- IRData/DRData hold their last value until the next completion on the same side.
- Err is 0 outside RESP.
- Request inputs changing while not granted are legal. Inputs changing while granted have no effect, because the Mem* outputs are registered.
- MemAck in IDLE or RESP is ignored.

Test Plan:
- Fetch read: IReq=1, IAdr=0x100, memory acks 2 cycles after MemReq with 0x00500093 -> MemAdr=0x100, MemByteEn=4'hF, MemWrite=0; IValid one cycle with IRData=0x00500093, Err=0; Busy returns 0.
- Simultaneous requests: IReq and DReq (load 0x2000) both asserted in IDLE -> D granted first, I granted after DValid. No overlap of MemReq between the two.
- Starvation: DReq held continuously with back-to-back loads and IReq held, MAX_DSTREAK=4 -> exactly 4 D grants, then an I grant, then D resumes.
- Store: DWrite=1, DAdr=0x3004, DWData=0xDEADBEEF, DByteEn=4'b0011 -> Mem* outputs match exactly; on ack, DValid=1 with DRData=0, Err=0.
- Timeout: TIMEOUT=8, MemAck never asserted -> MemReq high for 8 cycles then drops; DValid=1, Err=1, DRData=0. MemAck on cycle 8 gives Err=0 instead.
- Reset mid-transaction: assert reset while in BUSY_I -> outputs 0 immediately (asynchronous), no IValid pulse. After release with IReq still high, the fetch reissues and completes normally.
